iagc_control_fsm: RTL

Top-level control state machine of the IAGC. It consumes the UART receive strobe and the decoded command pulses from the command decoder, and publishes the `i_iagc_status` code that gates that decoder. It also sequences sample capture with decimation, memory clearing, and the memory dump to the UART transmitter.

---
 rtl/iagc_control_fsm.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/iagc_control_fsm.sv
// ---------------------------------------------------------------------------
// iagc_control_fsm
//
// Top-level control state machine of the IAGC. It takes the UART receive
// strobe and the decoded command lines, and publishes its state code on
// o_iagc_status, which the command decoder uses as a gate. It also sequences:
//   - sample capture with decimation into the sample memory,
//   - clearing the whole memory,
//   - dumping the captured samples to the UART transmitter.
//
// Ports
//   i_clock          system clock (rising edge)
//   i_reset          synchronous, active-high reset
//   i_rx_done        one-cycle pulse: a new command byte is on the rx bus
//   i_cmd_*          decoded command lines (valid while in CMD_READ)
//   i_cmd_param      command parameter; only the low nibble is used
//   i_sample_valid   one-cycle strobe: the sampler has a new sample
//   i_tx_done        one-cycle pulse: the UART tx finished the current byte
//   o_iagc_status    state code (the state register itself)
//   o_decim          active decimation factor
//   o_mem_wr_en      memory write strobe
//   o_mem_wr_zero    selects all-zero write data (memory clean)
//   o_mem_addr       memory read/write address
//   o_tx_start       one-cycle pulse: start a tx of the memory read data
//   o_mem_full       sticky: the memory was filled by a capture
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module iagc_control_fsm #(
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int DATA_SIZE        = 8,
    parameter int ADDR_SIZE        = 10,
    parameter int INIT_CYCLES      = 16
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_rx_done,
    input  logic                        i_cmd_reset,
    input  logic                        i_cmd_sample,
    input  logic                        i_cmd_set_decim,
    input  logic                        i_cmd_clean_mem,
    input  logic                        i_cmd_dump_mem,
    input  logic [DATA_SIZE-1:0]        i_cmd_param,
    input  logic                        i_sample_valid,
    input  logic                        i_tx_done,
    output logic [IAGC_STATUS_SIZE-1:0] o_iagc_status,
    output logic [DATA_SIZE-1:0]        o_decim,
    output logic                        o_mem_wr_en,
    output logic                        o_mem_wr_zero,
    output logic [ADDR_SIZE-1:0]        o_mem_addr,
    output logic                        o_tx_start,
    output logic                        o_mem_full
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    localparam logic [ADDR_SIZE-1:0] ADDR_MAX  = '1;
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE:0]   FILL_ONE  = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE:0]   FILL_FULL = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [DATA_SIZE-1:0] DATA_ONE  = DATA_SIZE'(1);
    localparam logic [INIT_W-1:0]    INIT_LAST = INIT_W'(INIT_CYCLES - 1);

    typedef enum logic [IAGC_STATUS_SIZE-1:0] {
        ST_RESET     = IAGC_STATUS_SIZE'(0),
        ST_INIT      = IAGC_STATUS_SIZE'(1),
        ST_IDLE      = IAGC_STATUS_SIZE'(2),
        ST_SAMPLE    = IAGC_STATUS_SIZE'(3),
        ST_CMD_PARSE = IAGC_STATUS_SIZE'(4),
        ST_CMD_READ  = IAGC_STATUS_SIZE'(5),
        ST_CMD_ERROR = IAGC_STATUS_SIZE'(6),
        ST_DUMP_MEM  = IAGC_STATUS_SIZE'(7),
        ST_CLEAN_MEM = IAGC_STATUS_SIZE'(8)
    } state_t;

    state_t                 state, state_n;
    logic [INIT_W-1:0]      init_cnt, init_cnt_n;
    logic [DATA_SIZE-1:0]   decim, decim_n;
    logic [DATA_SIZE-1:0]   dec_cnt, dec_cnt_n;
    logic [ADDR_SIZE-1:0]   addr, addr_n;
    logic [ADDR_SIZE:0]     fill, fill_n;
    logic                   full, full_n;
    logic                   wr_en, wr_en_n;
    logic                   wr_zero, wr_zero_n;
    logic                   tx_start, tx_start_n;
    logic                   dump_ph, dump_ph_n;   // 0: issue tx, 1: wait tx_done
    logic                   load_rst;
    logic                   wr_pend;
    logic [4:0]             cmd_vec;

    // Only the low nibble of the parameter carries information.
    logic unused_param;
    assign unused_param = ^i_cmd_param[DATA_SIZE-1:4];

    // A capture write is shown with its own address; the address and the
    // fill count advance on the cycle after the write strobe.
    assign wr_pend = wr_en & ~wr_zero;
    assign cmd_vec = {i_cmd_reset, i_cmd_sample, i_cmd_set_decim,
                      i_cmd_clean_mem, i_cmd_dump_mem};

    always_comb begin
        state_n    = state;
        init_cnt_n = init_cnt;
        decim_n    = decim;
        dec_cnt_n  = dec_cnt;
        addr_n     = addr;
        fill_n     = fill;
        full_n     = full;
        wr_en_n    = 1'b0;
        wr_zero_n  = 1'b0;
        tx_start_n = 1'b0;
        dump_ph_n  = dump_ph;
        load_rst   = 1'b0;

        if (wr_pend) begin
            // A full memory parks the address on the last word.
            if (addr != ADDR_MAX)  addr_n = addr + ADDR_ONE;
            if (fill != FILL_FULL) fill_n = fill + FILL_ONE;
        end

        case (state)
            ST_RESET: begin
                load_rst = 1'b1;
                state_n  = ST_INIT;
            end

            ST_INIT: begin
                if (init_cnt == INIT_LAST) state_n = ST_IDLE;
                else                       init_cnt_n = init_cnt + INIT_W'(1);
            end

            ST_IDLE: begin
                if (i_rx_done) state_n = ST_CMD_PARSE;
            end

            ST_CMD_PARSE: state_n = ST_CMD_READ;

            ST_CMD_READ: begin
                case (cmd_vec)
                    5'b10000: begin
                        state_n  = ST_RESET;
                        load_rst = 1'b1;
                    end
                    5'b01000: begin
                        state_n   = ST_SAMPLE;
                        dec_cnt_n = '0;
                        full_n    = 1'b0;
                    end
                    5'b00100: begin
                        decim_n = (i_cmd_param[3:0] == 4'd0) ? DATA_ONE
                                                             : DATA_SIZE'(i_cmd_param[3:0]);
                        state_n = ST_IDLE;
                    end
                    5'b00010: begin
                        // The first zero write is already on the bus in the
                        // first CLEAN_MEM cycle.
                        state_n   = ST_CLEAN_MEM;
                        addr_n    = '0;
                        wr_en_n   = 1'b1;
                        wr_zero_n = 1'b1;
                    end
                    5'b00001: begin
                        state_n   = ST_DUMP_MEM;
                        addr_n    = '0;
                        dump_ph_n = 1'b0;
                    end
                    default: state_n = ST_CMD_ERROR;
                endcase
            end

            ST_CMD_ERROR: state_n = ST_IDLE;

            ST_SAMPLE: begin
                if (i_sample_valid) begin
                    if (dec_cnt == decim - DATA_ONE) begin
                        dec_cnt_n = '0;
                        wr_en_n   = 1'b1;
                        // addr_n already includes any pending advance, so it
                        // is the address this write is going to use.
                        if (addr_n == ADDR_MAX) begin
                            full_n  = 1'b1;
                            state_n = ST_IDLE;
                        end
                    end else begin
                        dec_cnt_n = dec_cnt + DATA_ONE;
                    end
                end
                // Abort takes priority over the end-of-memory exit. A write
                // qualified in this cycle is still issued.
                if (i_rx_done) state_n = ST_CMD_PARSE;
            end

            ST_CLEAN_MEM: begin
                if (addr == ADDR_MAX) begin
                    addr_n  = '0;
                    fill_n  = '0;
                    full_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    addr_n    = addr + ADDR_ONE;
                    wr_en_n   = 1'b1;
                    wr_zero_n = 1'b1;
                end
            end

            ST_DUMP_MEM: begin
                if (fill == '0) begin
                    addr_n  = '0;
                    state_n = ST_IDLE;
                end else if (!dump_ph) begin
                    // Address has been on the bus for a cycle: read data is ready.
                    tx_start_n = 1'b1;
                    dump_ph_n  = 1'b1;
                end else if (i_tx_done) begin
                    dump_ph_n = 1'b0;
                    if ({1'b0, addr} == fill - FILL_ONE) begin
                        addr_n  = fill[ADDR_SIZE-1:0];
                        state_n = ST_IDLE;
                    end else begin
                        addr_n = addr + ADDR_ONE;
                    end
                end
            end

            default: state_n = ST_RESET;
        endcase

        if (load_rst) begin
            init_cnt_n = '0;
            decim_n    = DATA_ONE;
            dec_cnt_n  = '0;
            addr_n     = '0;
            fill_n     = '0;
            full_n     = 1'b0;
            dump_ph_n  = 1'b0;
            wr_en_n    = 1'b0;
            wr_zero_n  = 1'b0;
            tx_start_n = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= ST_RESET;
            init_cnt <= '0;
            decim    <= DATA_ONE;
            dec_cnt  <= '0;
            addr     <= '0;
            fill     <= '0;
            full     <= 1'b0;
            wr_en    <= 1'b0;
            wr_zero  <= 1'b0;
            tx_start <= 1'b0;
            dump_ph  <= 1'b0;
        end else begin
            state    <= state_n;
            init_cnt <= init_cnt_n;
            decim    <= decim_n;
            dec_cnt  <= dec_cnt_n;
            addr     <= addr_n;
            fill     <= fill_n;
            full     <= full_n;
            wr_en    <= wr_en_n;
            wr_zero  <= wr_zero_n;
            tx_start <= tx_start_n;
            dump_ph  <= dump_ph_n;
        end
    end

    assign o_iagc_status = state;
    assign o_decim       = decim;
    assign o_mem_wr_en   = wr_en;
    assign o_mem_wr_zero = wr_zero;
    assign o_mem_addr    = addr;
    assign o_tx_start    = tx_start;
    assign o_mem_full    = full;

endmodule
